// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, DMA and memory-side signals shared by the data-memory arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface dmem_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;

   logic        dma_start;
   logic [31:0] dma_base;
   logic [4:0]  dma_len;
   logic        dma_we;
   logic [31:0] dma_wdata;
   logic [3:0]  dma_idx;
   logic        dma_beat;
   logic [31:0] dma_rdata;
   logic        dma_busy;
   logic        dma_done;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_start, dma_base, dma_len, dma_we, dma_wdata,
      output dma_idx, dma_beat, dma_rdata, dma_busy, dma_done,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_start, dma_base, dma_len, dma_we, dma_wdata,
      input  dma_idx, dma_beat, dma_rdata, dma_busy, dma_done,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage has priority, a DMA burst takes
// idle cycles and is forced through after STARVE_LIMIT consecutive blocked cycles.
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam int WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_FORCE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [31:0]         base_q,  base_d;
   logic [4:0]          len_q,   len_d;
   logic                we_q,    we_d;
   logic [3:0]          idx_q,   idx_d;
   logic [WAIT_W-1:0]   wait_q,  wait_d;
   logic                done_q,  done_d;

   logic                dma_own;
   logic                accept;
   logic                wait_hit;
   logic                last_beat;
   logic [31:0]         beat_addr;

   assign accept    = (state_q == S_IDLE) && bus.dma_start && (bus.dma_len != 5'd0);
   // The CPU cycle that brings the counter up to the limit is the last one it wins.
   assign wait_hit  = ((32'(wait_q) + 32'd1) >= STARVE_LIMIT);
   // idx_q==15 also ends a burst so an out-of-range length can never run forever.
   assign last_beat = ({1'b0, idx_q} == (len_q - 5'd1)) || (idx_q == 4'hF);
   assign beat_addr = base_q + {26'd0, idx_q, 2'b00};

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      we_d    = we_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      done_d  = 1'b0;
      dma_own = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               base_d  = bus.dma_base;
               len_d   = bus.dma_len;
               we_d    = bus.dma_we;
               idx_d   = 4'd0;
               wait_d  = '0;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (!bus.cpu_req) begin
               dma_own = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
               if (wait_hit) begin
                  state_d = S_FORCE;
               end
            end
         end
         S_FORCE: begin
            dma_own = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (dma_own) begin
         wait_d = '0;
         if (last_beat) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
            done_d  = 1'b1;
         end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_BURST;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         base_q  <= 32'd0;
         len_q   <= 5'd0;
         we_q    <= 1'b0;
         idx_q   <= 4'd0;
         wait_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         done_q  <= done_d;
      end
   end

   // Port mux: exactly one owner per cycle, DMA only when dma_own.
   assign bus.mem_addr  = dma_own ? beat_addr     : bus.cpu_addr;
   assign bus.mem_wdata = dma_own ? bus.dma_wdata : bus.cpu_wdata;
   assign bus.mem_we    = dma_own ? we_q          : (bus.cpu_req & bus.cpu_we);

   assign bus.cpu_rdata = bus.mem_rdata;
   assign bus.cpu_stall = dma_own & bus.cpu_req;
   assign bus.dma_rdata = bus.mem_rdata;
   assign bus.dma_beat  = dma_own;
   assign bus.dma_idx   = idx_q;
   assign bus.dma_busy  = (state_q != S_IDLE);
   assign bus.dma_done  = done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_dmem_arbiter;
   localparam int LIMIT = 4;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical memory seen by the DUT: combinational read, write at the edge.
   logic [31:0] pmem [256];
   assign bus.mem_rdata = pmem[bus.mem_addr[9:2]];

   initial begin
      for (int i = 0; i < 256; i++) pmem[i] = 32'd0;
      forever begin
         @(posedge clk);
         if (bus.mem_we) pmem[bus.mem_addr[9:2]] = bus.mem_wdata;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a burst is just (base, len, we, beats done, cycles blocked).
   logic [31:0] mmem [256];
   logic        m_busy, m_we, m_done;
   logic [31:0] m_base;
   int          m_len, m_beats, m_blocked;

   initial begin
      logic        own, ewe, was_busy;
      logic [31:0] eaddr, ewdata;
      for (int i = 0; i < 256; i++) mmem[i] = 32'd0;
      m_busy = 0; m_we = 0; m_done = 0; m_base = 0;
      m_len = 0; m_beats = 0; m_blocked = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_busy = 0; m_done = 0; m_beats = 0; m_blocked = 0;
            chk("rst_beat",  32'(bus.dma_beat),  32'd0);
            chk("rst_busy",  32'(bus.dma_busy),  32'd0);
            chk("rst_done",  32'(bus.dma_done),  32'd0);
            chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
            chk("rst_idx",   32'(bus.dma_idx),   32'd0);
         end else begin
            own    = m_busy && (!bus.cpu_req || m_blocked >= LIMIT);
            eaddr  = own ? m_base + 32'(4 * m_beats) : bus.cpu_addr;
            ewe    = own ? m_we : (bus.cpu_req & bus.cpu_we);
            ewdata = own ? bus.dma_wdata : bus.cpu_wdata;

            chk("beat",  32'(bus.dma_beat),  32'(own));
            chk("stall", 32'(bus.cpu_stall), 32'(own && bus.cpu_req));
            chk("busy",  32'(bus.dma_busy),  32'(m_busy));
            chk("done",  32'(bus.dma_done),  32'(m_done));
            chk("idx",   32'(bus.dma_idx),   32'(m_beats));
            chk("mem_we", 32'(bus.mem_we),   32'(ewe));
            if (own || bus.cpu_req) chk("mem_addr", bus.mem_addr, eaddr);
            if (ewe) chk("mem_wdata", bus.mem_wdata, ewdata);
            if (!ewe && bus.cpu_req && !own) chk("cpu_rdata", bus.cpu_rdata, mmem[eaddr[9:2]]);
            if (!ewe && own) chk("dma_rdata", bus.dma_rdata, mmem[eaddr[9:2]]);

            was_busy = m_busy;
            m_done   = 0;
            if (ewe) mmem[eaddr[9:2]] = ewdata;
            if (own) begin
               m_beats++;
               m_blocked = 0;
               if (m_beats == m_len) begin
                  m_busy  = 0;
                  m_done  = 1;
                  m_beats = 0;
               end
            end else if (m_busy && bus.cpu_req) begin
               m_blocked++;
            end
            if (!was_busy && bus.dma_start && bus.dma_len != 5'd0) begin
               m_busy = 1; m_base = bus.dma_base; m_len = int'(bus.dma_len);
               m_we = bus.dma_we; m_beats = 0; m_blocked = 0;
            end
         end
      end
   end

   // Observation window used by the directed scenarios.
   logic        ob_beat  [32];
   logic        ob_stall [32];
   logic        ob_done  [32];
   logic        ob_busy  [32];
   logic [31:0] ob_addr  [32];

   task automatic step();
      @(posedge clk);
      #1;
      bus.dma_wdata = $urandom;
   endtask

   task automatic observe(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         ob_beat[c]  = bus.dma_beat;
         ob_stall[c] = bus.cpu_stall;
         ob_done[c]  = bus.dma_done;
         ob_busy[c]  = bus.dma_busy;
         ob_addr[c]  = bus.mem_addr;
         step();
      end
   endtask

   task automatic start_dma(input logic [31:0] base, input logic [4:0] len, input logic we);
      bus.dma_start = 1'b1;
      bus.dma_base  = base;
      bus.dma_len   = len;
      bus.dma_we    = we;
      step();
      bus.dma_start = 1'b0;
   endtask

   initial begin
      int nb, nd, bias;
      reset = 1'b0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
      bus.dma_start = 0; bus.dma_base = 0; bus.dma_len = 0; bus.dma_we = 0;
      bus.dma_wdata = 0;
      repeat (2) @(negedge clk);
      chk("init_busy", 32'(bus.dma_busy), 32'd0);
      chk("init_idx",  32'(bus.dma_idx),  32'd0);
      step();
      reset = 1'b1;

      // Idle CPU write then read-back.
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("idle_we",    32'(bus.mem_we),    32'd1);
      chk("idle_addr",  bus.mem_addr,       32'h10);
      chk("idle_stall", 32'(bus.cpu_stall), 32'd0);
      step();
      bus.cpu_we = 0;
      @(negedge clk);
      chk("idle_rdata", bus.cpu_rdata,      32'hDEADBEEF);
      chk("idle_stall2", 32'(bus.cpu_stall), 32'd0);
      step();
      bus.cpu_req = 0;

      // Uncontended write burst of 4.
      start_dma(32'h100, 5'd4, 1'b1);
      observe(6);
      nb = 0;
      for (int c = 0; c < 6; c++) begin
         nb += int'(ob_beat[c]);
         chk("b4_done", 32'(ob_done[c]), 32'(c == 4));
         if (c < 4) chk("b4_addr", ob_addr[c], 32'h100 + 32'(4 * c));
      end
      chk("b4_beats", 32'(nb), 32'd4);

      // Starvation: CPU holds the port, beats are forced every fifth cycle.
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
      start_dma(32'h180, 5'd2, 1'b0);
      observe(12);
      for (int c = 0; c < 12; c++) begin
         chk("sv_beat",  32'(ob_beat[c]),  32'(c == 4 || c == 9));
         chk("sv_stall", 32'(ob_stall[c]), 32'(c == 4 || c == 9));
         chk("sv_done",  32'(ob_done[c]),  32'(c == 10));
         chk("sv_busy",  32'(ob_busy[c]),  32'(c < 10));
      end
      bus.cpu_req = 0;

      // Zero-length start is ignored.
      start_dma(32'h400, 5'd0, 1'b1);
      observe(4);
      nb = 0; nd = 0;
      for (int c = 0; c < 4; c++) begin
         nb += int'(ob_beat[c]); nd += int'(ob_done[c]) + int'(ob_busy[c]);
      end
      chk("z_beats", 32'(nb), 32'd0);
      chk("z_other", 32'(nd), 32'd0);

      // Start while busy is ignored.
      bus.cpu_req = 1;
      start_dma(32'h200, 5'd2, 1'b1);
      bus.dma_start = 1; bus.dma_base = 32'h300; bus.dma_len = 5'd5;
      step();
      bus.dma_start = 0; bus.cpu_req = 0;
      observe(8);
      nb = 0; nd = 0;
      for (int c = 0; c < 8; c++) begin
         nb += int'(ob_beat[c]); nd += int'(ob_done[c]);
      end
      chk("bz_beats", 32'(nb), 32'd2);
      chk("bz_dones", 32'(nd), 32'd1);
      chk("bz_addr0", ob_addr[0], 32'h200);
      chk("bz_addr1", ob_addr[1], 32'h204);

      // Address wrap-around.
      start_dma(32'hFFFFFFF8, 5'd3, 1'b1);
      observe(5);
      chk("wr_addr0", ob_addr[0], 32'hFFFFFFF8);
      chk("wr_addr1", ob_addr[1], 32'hFFFFFFFC);
      chk("wr_addr2", ob_addr[2], 32'h00000000);
      chk("wr_done",  32'(ob_done[3]), 32'd1);

      // Reset in the middle of a long burst.
      start_dma(32'h500, 5'd8, 1'b1);
      step();
      step();
      #2 reset = 1'b0;
      #1;
      chk("mr_beat",  32'(bus.dma_beat),  32'd0);
      chk("mr_busy",  32'(bus.dma_busy),  32'd0);
      chk("mr_idx",   32'(bus.dma_idx),   32'd0);
      chk("mr_done",  32'(bus.dma_done),  32'd0);
      step();
      reset = 1'b1;
      observe(12);
      nb = 0; nd = 0;
      for (int c = 0; c < 12; c++) begin
         nb += int'(ob_beat[c]) + int'(ob_busy[c]); nd += int'(ob_done[c]);
      end
      chk("mr_after", 32'(nb), 32'd0);
      chk("mr_ndone", 32'(nd), 32'd0);

      // Randomized traffic with bursts of CPU pressure.
      bias = 50;
      for (int i = 0; i < 4000; i++) begin
         if (i % 16 == 0) bias = (($urandom_range(0, 1) == 1) ? 90 : 30);
         bus.cpu_req   = ($urandom_range(0, 99) < bias);
         bus.cpu_we    = $urandom_range(0, 1) == 1;
         bus.cpu_addr  = $urandom;
         bus.cpu_wdata = $urandom;
         bus.dma_start = ($urandom_range(0, 9) == 0);
         bus.dma_len   = 5'($urandom_range(0, 16));
         bus.dma_base  = $urandom & 32'hFFFF_FFFC;
         bus.dma_we    = $urandom_range(0, 1) == 1;
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive cycles a pending DMA beat may be blocked by CPU before it is forced.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 cpu_req  input  1  MEM-stage access request this cycle.
REQ-005 cpu_we  input  1  MEM-stage write enable (valid with cpu_req).
REQ-006 cpu_addr  input  32  MEM-stage byte address.
REQ-007 cpu_wdata  input  32  MEM-stage store data.
REQ-008 cpu_rdata  output  32  read data to MEM stage (= mem_rdata).
REQ-009 cpu_stall  output  1  MEM stage must hold; port not granted to CPU this cycle.
REQ-010 dma_start  input  1  one-cycle pulse launching a burst.
REQ-011 dma_base  input  32  burst start byte address, sampled on accepted dma_start.
REQ-012 dma_len  input  5  burst length in words, 1..16 valid; sampled with dma_start.
REQ-013 dma_we  input  1  burst direction, 1 = write to memory; sampled with dma_start.
REQ-014 dma_wdata  input  32  write data for current beat (beat index dma_idx).
REQ-015 dma_idx  output  4  index of the beat currently offered.
REQ-016 dma_beat  output  1  DMA owns memory port this cycle; beat completes at next edge.
REQ-017 dma_rdata  output  32  read data for current beat (= mem_rdata).
REQ-018 dma_busy  output  1  burst in progress.
REQ-019 dma_done  output  1  one-cycle pulse after final beat.
REQ-020 mem_addr / mem_wdata  output  32 / 32  to single-port data memory.
REQ-021 mem_we  output  1  memory write enable; memory reads combinationally, writes at edge.
REQ-022 mem_rdata  input  32  memory read data.

Function
REQ-023 States: IDLE, BURST, FORCE; reset state IDLE.
REQ-024 IDLE: port routed to CPU (mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req&cpu_we), cpu_stall=0, dma_beat=0.
REQ-025 dma_start accepted only when dma_busy=0 and dma_len!=0; accepted start latches base/len/we, clears beat index and wait counter, next state BURST.
REQ-026 dma_start with dma_len=0 or while dma_busy=1 shall be ignored with no side effects.
REQ-027 BURST, cpu_req=0: DMA owns port; mem_addr=base+4*dma_idx, mem_we=latched we, mem_wdata=dma_wdata, dma_beat=1.
REQ-028 BURST, cpu_req=1 and wait counter<STARVE_LIMIT: CPU owns port, cpu_stall=0, wait counter increments.
REQ-029 BURST, cpu_req=1 and wait counter reaches STARVE_LIMIT: next state FORCE.
REQ-030 FORCE: DMA owns port for exactly one cycle, cpu_stall=cpu_req, wait counter clears, return to BURST (or finish per REQ-032).
REQ-031 Each DMA-owned cycle increments dma_idx at the edge and clears wait counter.
REQ-032 When the beat with dma_idx=len-1 completes: next state IDLE, dma_busy=0 and dma_done=1 for one cycle.
REQ-033 cpu_stall=1 only when cpu_req=1 and DMA owns port; never asserted without cpu_req.
REQ-034 Address arithmetic modulo 2^32; base+4*idx wrap-around permitted and not flagged.
REQ-035 dma_busy=1 from cycle after accepted start through cycle of final beat inclusive.
REQ-036 Never more than one owner per cycle; mem_we=0 when owner's write enable is 0.

Reset
REQ-037 reset=0 shall asynchronously force IDLE, dma_busy=0, dma_done=0, dma_beat=0, cpu_stall=0, dma_idx=0, wait counter 0, latched registers 0.
REQ-038 Reset mid-burst abandons the burst; no dma_done is generated.

Verification
REQ-039 Idle CPU traffic: cpu_req=1, cpu_we=1, addr 0x10, data 0xDEADBEEF, then read 0x10 -> cpu_stall=0, cpu_rdata=0xDEADBEEF next cycle.
REQ-040 DMA write burst base 0x100, len 4, cpu_req=0 -> dma_beat 4 consecutive cycles, addrs 0x100..0x10C, dma_done one cycle after 4th beat.
REQ-041 Starvation: len 2, cpu_req held 1 -> 4 CPU cycles, then 1 FORCE beat with cpu_stall=1, repeat; dma_done after 10 cycles.
REQ-042 dma_start while busy and dma_start with len 0 -> ignored, no beats, no dma_done.
REQ-043 Wrap: base 0xFFFFFFF8, len 3 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-044 reset=0 asserted during beat 2 of len-8 burst -> all outputs zero immediately, no dma_done, IDLE after release.
